// File: rtl/booth_mac_acc.sv
// Saturating group accumulator behind a fixed-latency Booth multiplier.
// A {valid,last} tag pipeline tracks each beat; a credit-protected FWFT FIFO delivers the group sums.
module booth_mac_acc #(
   parameter int PROD_W     = 16,
   parameter int ACC_W      = 24,
   parameter int LAT        = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              issue_valid_i,
   input  logic              issue_last_i,
   output logic              issue_ready_o,
   input  logic [PROD_W-1:0] product_i,
   output logic [ACC_W-1:0]  acc_data_o,
   output logic              acc_ovf_o,
   output logic              acc_valid_o,
   input  logic              acc_ready_i,
   output logic              busy_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_W = $clog2(LAT + FIFO_DEPTH + 1) + 1;

   logic [LAT-1:0]   tagValid_q, tagLast_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             groupOpen_q, groupOpen_d;
   logic [ACC_W:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0] count_q;

   logic             accept;
   logic [ACC_W:0]   sumExt;
   logic             clampNow;
   logic [ACC_W-1:0] satSum;
   logic             push, pop, fifoEmpty;
   logic [CRD_W-1:0] lastsInflight, credit;

   assign accept    = issue_valid_i & issue_ready_o;
   assign fifoEmpty = (count_q == '0);
   assign push      = tagValid_q[LAT-1] & tagLast_q[LAT-1];
   assign pop       = acc_ready_i & ~fifoEmpty;

   // Credits reserve a FIFO slot for every last already issued, so pushes never meet a full FIFO.
   always_comb begin
      lastsInflight = '0;
      for (int k = 0; k < LAT; k++) begin
         lastsInflight = lastsInflight + CRD_W'(tagLast_q[k]);
      end
      credit        = lastsInflight + CRD_W'(count_q);
      issue_ready_o = (credit < CRD_W'(FIFO_DEPTH));
   end

   // One guard bit above the accumulator detects overflow; clamp toward the sign of the true sum.
   always_comb begin
      sumExt   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){product_i[PROD_W-1]}}, product_i};
      clampNow = sumExt[ACC_W] ^ sumExt[ACC_W-1];
      satSum   = sumExt[ACC_W-1:0];
      if (clampNow) begin
         satSum = sumExt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   always_comb begin
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      groupOpen_d = groupOpen_q;
      if (tagValid_q[LAT-1]) begin
         if (tagLast_q[LAT-1]) begin
            acc_d       = '0;
            ovf_d       = 1'b0;
            groupOpen_d = 1'b0;
         end else begin
            acc_d       = satSum;
            ovf_d       = ovf_q | clampNow;
            groupOpen_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tagValid_q  <= '0;
         tagLast_q   <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         groupOpen_q <= 1'b0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
      end else begin
         tagValid_q  <= {tagValid_q[LAT-2:0], accept};
         tagLast_q   <= {tagLast_q[LAT-2:0], accept & issue_last_i};
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         groupOpen_q <= groupOpen_d;
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wrPtr_q] <= {ovf_q | clampNow, satSum};
   end

   assign acc_valid_o = ~fifoEmpty;
   assign acc_data_o  = fifoEmpty ? '0 : mem_q[rdPtr_q][ACC_W-1:0];
   assign acc_ovf_o   = fifoEmpty ? 1'b0 : mem_q[rdPtr_q][ACC_W];
   assign busy_o      = (|tagValid_q) | groupOpen_q | ~fifoEmpty;

   pushNeverFull: assert property (@(posedge clk_i) disable iff (rst_i)
      push |-> (count_q != CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: behavioural multiplier pipeline, group-sum model and
// expected-result queue compared as the FIFO head is popped.
module tb_booth_mac_acc;

   localparam int PROD_W = 16;
   localparam int ACC_W  = 24;
   localparam int LAT    = 4;
   localparam int DEPTH  = 4;
   localparam longint ACC_MAX = 64'sd8388607;
   localparam longint ACC_MIN = -64'sd8388608;

   logic              clock = 1'b0;
   logic              reset;
   logic              issueValid, issueLast, issueReady;
   logic [PROD_W-1:0] product;
   logic [ACC_W-1:0]  accData;
   logic              accOvf, accValid, accReady, busy;

   logic signed [7:0]  md, mr;
   logic signed [15:0] mulNow;
   logic signed [15:0] mulPipe [LAT];

   int checks = 0;
   int errors = 0;

   logic [ACC_W:0] expQ [$];
   longint         modelAcc;
   bit             modelOvf;

   bit             prevHold;
   logic [ACC_W-1:0] prevData;
   logic           prevOvf;

   booth_mac_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i         (clock),
      .rst_i         (reset),
      .issue_valid_i (issueValid),
      .issue_last_i  (issueLast),
      .issue_ready_o (issueReady),
      .product_i     (product),
      .acc_data_o    (accData),
      .acc_ovf_o     (accOvf),
      .acc_valid_o   (accValid),
      .acc_ready_i   (accReady),
      .busy_o        (busy)
   );

   always #5 clock = ~clock;

   // Stand-in for the 4-stage multiplier; bubbles inject junk that the DUT must ignore.
   assign mulNow  = 16'(md) * 16'(mr);
   assign product = mulPipe[LAT-1];

   always @(posedge clock) begin
      mulPipe[0] <= (issueValid && issueReady) ? mulNow : 16'shDEAD;
      for (int k = 1; k < LAT; k++) mulPipe[k] <= mulPipe[k-1];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Head-of-FIFO scoreboard plus hold-stability and empty-zero checks.
   always @(negedge clock) begin
      if (reset) begin
         prevHold = 1'b0;
      end else begin
         if (prevHold) begin
            checkOutput("holdValid", 32'(accValid), 32'd1);
            checkOutput("holdData", 32'(accData), 32'(prevData));
            checkOutput("holdOvf", 32'(accOvf), 32'(prevOvf));
         end
         if (!accValid) begin
            checkOutput("emptyData", 32'(accData), 32'd0);
            checkOutput("emptyOvf", 32'(accOvf), 32'd0);
         end
         if (accValid && accReady) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedPop", 32'(accValid), 32'd0);
            end else begin
               logic [ACC_W:0] e;
               e = expQ.pop_front();
               checkOutput("popData", 32'(accData), 32'(e[ACC_W-1:0]));
               checkOutput("popOvf", 32'(accOvf), 32'(e[ACC_W]));
            end
         end
         prevHold = accValid && !accReady;
         prevData = accData;
         prevOvf  = accOvf;
      end
   end

   task automatic modelAccept();
      longint s;
      bit     clamp;
      s     = modelAcc + longint'(mulNow);
      clamp = 1'b0;
      if (s > ACC_MAX) begin s = ACC_MAX; clamp = 1'b1; end
      if (s < ACC_MIN) begin s = ACC_MIN; clamp = 1'b1; end
      if (issueLast) begin
         expQ.push_back({modelOvf | clamp, s[ACC_W-1:0]});
         modelAcc = 0;
         modelOvf = 1'b0;
      end else begin
         modelAcc = s;
         modelOvf = modelOvf | clamp;
      end
   endtask

   task automatic applyStimulus(input int a, input int b, input bit last);
      md         = 8'(a);
      mr         = 8'(b);
      issueLast  = last;
      issueValid = 1'b1;
   endtask

   task automatic waitAccept();
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clock);
         if (issueReady) begin
            modelAccept();
            done = 1'b1;
         end else if (++cyc > 200) begin
            checkOutput("acceptTimeout", 32'(issueReady), 32'd1);
            done = 1'b1;
         end
         @(posedge clock); #1;
      end
      issueValid = 1'b0;
      issueLast  = 1'b0;
   endtask

   task automatic beat(input int a, input int b, input bit last);
      applyStimulus(a, b, last);
      waitAccept();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (expQ.size() != 0 && cyc < 300) begin
         @(posedge clock); #1;
         cyc++;
      end
      checkOutput("drainPending", 32'(expQ.size()), 32'd0);
      idle(2);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "Ready"}, 32'(issueReady), 32'd1);
      checkOutput({tag, "Valid"}, 32'(accValid), 32'd0);
      checkOutput({tag, "Data"}, 32'(accData), 32'd0);
      checkOutput({tag, "Ovf"}, 32'(accOvf), 32'd0);
      checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      issueValid = 1'b0;
      issueLast  = 1'b0;
      accReady   = 1'b1;
      md         = '0;
      mr         = '0;
      modelAcc   = 0;
      modelOvf   = 1'b0;
      prevHold   = 1'b0;
      idle(3);
      checkResetValues("reset");
      reset = 1'b0;
      idle(2);

      // Three-beat group: 15 - 6 + 100 = 109, visible exactly LAT edges after the last accept.
      $display("[TB] three-beat group");
      beat(3, 5, 1'b0);
      beat(-2, 3, 1'b0);
      beat(10, 10, 1'b1);
      idle(LAT - 1);
      checkOutput("g1NotYet", 32'(accValid), 32'd0);
      idle(1);
      checkOutput("g1Valid", 32'(accValid), 32'd1);
      checkOutput("g1Data", 32'(accData), 32'h00006D);
      drain();
      checkOutput("g1Busy", 32'(busy), 32'd0);

      $display("[TB] single-beat group");
      beat(-128, -128, 1'b1);
      drain();

      // 600 * 16384 exceeds the 24-bit range; the next group must start clean.
      $display("[TB] saturation");
      for (int i = 0; i < 600; i++) beat(-128, -128, i == 599);
      drain();
      beat(1, 1, 1'b1);
      drain();

      $display("[TB] backpressure");
      accReady = 1'b0;
      for (int i = 1; i <= 4; i++) beat(1, i, 1'b1);
      checkOutput("bpReadyLow", 32'(issueReady), 32'd0);
      applyStimulus(1, 5, 1'b1);
      idle(LAT + 3);
      checkOutput("bpStillBlocked", 32'(issueReady), 32'd0);
      checkOutput("bpHeadData", 32'(accData), 32'd1);
      accReady = 1'b1;
      waitAccept();
      drain();

      // Three entries held, then a push lands on the same edge as a pop.
      $display("[TB] simultaneous push/pop with bubbles");
      accReady = 1'b0;
      beat(2, 3, 1'b0);
      idle(2);
      beat(4, 5, 1'b1);
      beat(-7, 9, 1'b1);
      beat(1, 1, 1'b0);
      idle(1);
      beat(-1, 1, 1'b0);
      idle(1);
      beat(100, 100, 1'b1);
      idle(LAT + 2);
      checkOutput("ppReadyAt3", 32'(issueReady), 32'd1);
      beat(3, 3, 1'b1);
      checkOutput("ppCreditFull", 32'(issueReady), 32'd0);
      idle(LAT - 1);
      accReady = 1'b1;
      idle(1);
      accReady = 1'b0;
      checkOutput("ppCountKept", 32'(issueReady), 32'd1);
      checkOutput("ppValid", 32'(accValid), 32'd1);
      checkOutput("ppHead", 32'hFFFFFF & 32'(accData), 32'hFFFFC1);
      accReady = 1'b1;
      drain();

      $display("[TB] reset mid-group");
      beat(5, 5, 1'b0);
      beat(6, 6, 1'b0);
      reset = 1'b1;
      #1;
      checkResetValues("midReset");
      modelAcc = 0;
      modelOvf = 1'b0;
      expQ.delete();
      idle(2);
      reset = 1'b0;
      idle(1);
      beat(7, 7, 1'b1);
      idle(LAT);
      checkOutput("postResetData", 32'(accData), 32'd49);
      drain();
      checkOutput("finalBusy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL globalTimeout observed=running expected=finished");
      $fatal(1, "[TB] time limit");
   end

endmodule
